emu_clk_ctrl: RTL and testbench
===============================

Name: emu_clk_ctrl

Overview:
- Sequences the emulator clock domain after the clock wizard output is stable.
- Waits for PLL/MMCM lock, then issues a fixed-length reset to the emulator (MSDSL) blocks.
- Then drives a registered clock-enable (emu_ce) under run, stop and single/multi-step commands.
- Sits between the clock generator and the emulated analog models; its command port is driven by the debug/VIO side.

Parameters:
- RST_CYCLES, 16, number of emu_clk cycles sys_rst is held high after lock or after a reset command (>=1).
- STEP_W, 32, width of the step count.
- DT_W, 32, width of the per-cycle emulated timestep.
- TIME_W, 64, width of the emulated time accumulator (>= DT_W).

Ports:
- emu_clk  in  1  emulator clock, from the clock wizard clk_out1.
- emu_rst  in  1  asynchronous, active-high reset.
- locked  in  1  clock wizard lock flag; asynchronous to emu_clk.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  command accept.
- cmd_op  in  2  00=STOP, 01=RUN, 10=STEP, 11=RESET.
- cmd_steps  in  STEP_W  cycle count for STEP.
- dt  in  DT_W  timestep added per enabled cycle.
- emu_ce  out  1  clock enable to the emulator datapath.
- sys_rst  out  1  reset to the emulator blocks.
- state  out  3  current FSM state encoding.
- steps_left  out  STEP_W  remaining STEP cycles.
- emu_time  out  TIME_W  emulated time; present only with the optional feature.

Behaviour:
- Async reset (emu_rst=1) gives:
  - state=WAIT_LOCK(0), emu_ce=0, sys_rst=1, cmd_ready=0, steps_left=0, emu_time=0.
  - Lock synchroniser flops cleared.
- locked passes through a 2-flop synchroniser (lock_s) before use.
  - Lock loss (lock_s=0) in any state, next cycle: state=WAIT_LOCK, emu_ce=0, sys_rst=1, steps_left=0.
- States and encodings: WAIT_LOCK=0, RESET=1, IDLE=2, RUN=3, STEP=4.
- WAIT_LOCK:
  - sys_rst=1, emu_ce=0, cmd_ready=0.
  - Goes to RESET on lock_s=1.
- RESET:
  - sys_rst=1, emu_ce=0, cmd_ready=0.
  - Internal counter loaded with RST_CYCLES on entry and decremented each cycle.
  - sys_rst stays high for exactly RST_CYCLES cycles in RESET, then the state goes to IDLE with sys_rst=0.
- cmd_ready=1 in IDLE, RUN and STEP; a command is accepted when cmd_valid & cmd_ready.
- Accepted commands, any of IDLE, RUN or STEP:
  - STOP: go to IDLE; steps_left=0.
  - RUN: go to RUN.
  - STEP with cmd_steps=0: no state change; steps_left unchanged.
  - STEP with N>0: go to STEP; steps_left=N. This reloads from RUN or from STEP.
  - RESET: go to RESET; the counter restarts.
- emu_ce is registered:
  - Equals 1 for every cycle the state register is RUN or STEP.
  - It is 1 beginning the cycle after an accepted RUN/STEP.
  - It is 0 beginning the cycle after an accepted STOP/RESET.
- STEP:
  - steps_left decrements on each emu_ce=1 cycle.
  - When steps_left reaches 1 and ce fires, the next state is IDLE with steps_left=0.
  - A STEP N therefore yields exactly N emu_ce-high cycles.
- Simultaneous events: lock loss overrides any command; a command accepted in the final STEP cycle overrides the return to IDLE.
- cmd_op, cmd_steps and dt are sampled only at acceptance or when used; no other buffering.

Optional Feature:
- Macro EMU_TIME_CNT_EN.
- When defined:
  - emu_time port and accumulator exist.
  - Cleared while sys_rst=1.
  - Adds zero-extended dt on each cycle emu_ce=1.
  - Wraps modulo 2^TIME_W.
  - Updated in the same cycle edge that ends the enabled cycle.
- When undefined: no emu_time port or accumulator; all other behaviour identical.

Test Plan:
- emu_rst pulse, locked=0 -> state=0, sys_rst=1, emu_ce=0, cmd_ready=0 indefinitely.
- locked rises, RST_CYCLES=16 -> state reaches RESET 2 cycles later (synchroniser); sys_rst high exactly 16 cycles in RESET; then IDLE, cmd_ready=1.
- STEP cmd_steps=5 from IDLE -> emu_ce high exactly 5 cycles; steps_left 5,4,3,2,1,0; returns to IDLE. STEP cmd_steps=0 -> no ce pulse.
- RUN then STOP after 10 cycles -> 10 emu_ce cycles. With EMU_TIME_CNT_EN and dt=3 -> emu_time=30; then RESET command -> emu_time=0 and sys_rst high 16 cycles.
- locked drops mid-RUN -> within 2 cycles state=WAIT_LOCK, emu_ce=0, sys_rst=1; a command pending during the drop is not accepted.
- TIME_W=8, dt=200, 2 enabled cycles -> emu_time=144 (wrap).

Source files
------------

// File: rtl/emu_clk_ctrl.sv
// ---------------------------------------------------------------------------
// emu_clk_ctrl
//
// Sequences the emulator clock domain once the clock wizard is stable:
// waits for PLL/MMCM lock, holds the emulator blocks in reset for a fixed
// number of cycles, then gates the emulator datapath with a registered clock
// enable under STOP / RUN / STEP / RESET commands from the debug side.
//
// Optional feature: define EMU_TIME_CNT_EN to add the emu_time port and an
// accumulator of emulated time (sum of dt over every enabled cycle).
//
// Ports:
//   emu_clk     in   emulator clock (clock wizard clk_out1)
//   emu_rst     in   asynchronous active-high reset
//   locked      in   clock wizard lock flag, asynchronous to emu_clk
//   cmd_valid   in   command strobe
//   cmd_ready   out  command accept (IDLE/RUN/STEP while lock is held)
//   cmd_op      in   00=STOP 01=RUN 10=STEP 11=RESET
//   cmd_steps   in   cycle count for STEP
//   dt          in   emulated timestep added per enabled cycle
//   emu_ce      out  registered clock enable to the emulator datapath
//   sys_rst     out  registered reset to the emulator blocks
//   state       out  FSM state (0=WAIT_LOCK 1=RESET 2=IDLE 3=RUN 4=STEP)
//   steps_left  out  remaining STEP cycles
//   emu_time    out  emulated time (EMU_TIME_CNT_EN only)
// ---------------------------------------------------------------------------
module emu_clk_ctrl #(
    parameter int RST_CYCLES = 16,
    parameter int STEP_W     = 32,
    parameter int DT_W       = 32,
    parameter int TIME_W     = 64
) (
    input  logic              emu_clk,
    input  logic              emu_rst,
    input  logic              locked,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [DT_W-1:0]   dt,
    output logic              emu_ce,
    output logic              sys_rst,
    output logic [2:0]        state,
    output logic [STEP_W-1:0] steps_left
`ifdef EMU_TIME_CNT_EN
    ,
    output logic [TIME_W-1:0] emu_time
`endif
);

    localparam int CNT_W = $clog2(RST_CYCLES + 1);

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_RESET = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_RESET     = 3'd1,
        S_IDLE      = 3'd2,
        S_RUN       = 3'd3,
        S_STEP      = 3'd4
    } state_t;

    state_t             cur_state;
    state_t             nxt_state;
    logic [CNT_W-1:0]   rst_cnt;
    logic [CNT_W-1:0]   nxt_cnt;
    logic [STEP_W-1:0]  nxt_steps;
    logic               lock_meta;
    logic               lock_s;
    logic               cmd_accept;
    logic               ce_nxt;
    logic               srst_nxt;

    // Two-flop synchroniser for the asynchronous lock flag.
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= locked;
            lock_s    <= lock_meta;
        end
    end

    // State register, together with the registered outputs derived from the
    // next state so that emu_ce / sys_rst line up exactly with the state.
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            cur_state  <= S_WAIT_LOCK;
            rst_cnt    <= '0;
            steps_left <= '0;
            emu_ce     <= 1'b0;
            sys_rst    <= 1'b1;
        end else begin
            cur_state  <= nxt_state;
            rst_cnt    <= nxt_cnt;
            steps_left <= nxt_steps;
            emu_ce     <= ce_nxt;
            sys_rst    <= srst_nxt;
        end
    end

    // Next-state logic. Lock loss wins over everything; in IDLE/RUN/STEP the
    // natural STEP countdown is computed first so an accepted command in the
    // final STEP cycle overrides the return to IDLE.
    always_comb begin
        nxt_state = cur_state;
        nxt_cnt   = rst_cnt;
        nxt_steps = steps_left;
        if (!lock_s) begin
            nxt_state = S_WAIT_LOCK;
            nxt_steps = '0;
        end else begin
            case (cur_state)
                S_WAIT_LOCK: begin
                    nxt_state = S_RESET;
                    nxt_cnt   = CNT_W'(RST_CYCLES);
                end
                S_RESET: begin
                    // Counter holds the number of RESET cycles still to go,
                    // including the current one.
                    if (rst_cnt <= CNT_W'(1)) begin
                        nxt_state = S_IDLE;
                    end else begin
                        nxt_cnt = rst_cnt - CNT_W'(1);
                    end
                end
                S_IDLE, S_RUN, S_STEP: begin
                    if (cur_state == S_STEP) begin
                        if (steps_left <= STEP_W'(1)) begin
                            nxt_state = S_IDLE;
                            nxt_steps = '0;
                        end else begin
                            nxt_steps = steps_left - STEP_W'(1);
                        end
                    end
                    if (cmd_accept) begin
                        case (cmd_op)
                            OP_STOP: begin
                                nxt_state = S_IDLE;
                                nxt_steps = '0;
                            end
                            OP_RUN: begin
                                nxt_state = S_RUN;
                                nxt_steps = '0;
                            end
                            OP_STEP: begin
                                // A zero-length STEP is a no-op.
                                if (cmd_steps != '0) begin
                                    nxt_state = S_STEP;
                                    nxt_steps = cmd_steps;
                                end
                            end
                            OP_RESET: begin
                                nxt_state = S_RESET;
                                nxt_cnt   = CNT_W'(RST_CYCLES);
                                nxt_steps = '0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    nxt_state = S_WAIT_LOCK;
                    nxt_steps = '0;
                end
            endcase
        end
    end

    // Output logic. cmd_ready is withheld once the synchronised lock has
    // dropped so a command pending during lock loss is never accepted.
    always_comb begin
        cmd_ready = 1'b0;
        ce_nxt    = 1'b0;
        srst_nxt  = 1'b0;
        if (lock_s && (cur_state == S_IDLE || cur_state == S_RUN ||
                       cur_state == S_STEP)) begin
            cmd_ready = 1'b1;
        end
        if (nxt_state == S_RUN || nxt_state == S_STEP) begin
            ce_nxt = 1'b1;
        end
        if (nxt_state == S_WAIT_LOCK || nxt_state == S_RESET) begin
            srst_nxt = 1'b1;
        end
    end

    assign cmd_accept = cmd_valid & cmd_ready;
    assign state      = cur_state;

`ifdef EMU_TIME_CNT_EN
    // Emulated time: cleared while the emulator is in reset, advanced by dt
    // at the edge that ends each enabled cycle, wrapping naturally.
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            emu_time <= '0;
        end else if (sys_rst) begin
            emu_time <= '0;
        end else if (emu_ce) begin
            emu_time <= emu_time + TIME_W'(dt);
        end
    end
`else
    logic dt_unused;
    assign dt_unused = ^dt;
`endif

endmodule

// File: tb/tb_emu_clk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_emu_clk_ctrl
//
// Scoreboard bench for emu_clk_ctrl. The driver applies inputs on the falling
// edge, advances a behavioural model of the controller by one cycle and
// queues the expected outputs; a monitor pops one entry after each rising
// edge and compares every output. Directed phases cover reset, lock-up,
// STEP/RUN/STOP/RESET commands, lock loss and time wrap; a randomized phase
// follows. Define EMU_TIME_CNT_EN to also check emu_time.
// ---------------------------------------------------------------------------
module tb_emu_clk_ctrl;

    localparam int RSTC = 16;
    localparam int SW   = 8;
    localparam int DW   = 8;
    localparam int TW   = 8;

    logic          emu_clk   = 1'b0;
    logic          emu_rst   = 1'b1;
    logic          locked    = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op    = 2'b00;
    logic [SW-1:0] cmd_steps = '0;
    logic [DW-1:0] dt        = '0;
    wire           cmd_ready;
    wire           emu_ce;
    wire           sys_rst;
    wire [2:0]     state;
    wire [SW-1:0]  steps_left;
`ifdef EMU_TIME_CNT_EN
    wire [TW-1:0]  emu_time;
`endif

    emu_clk_ctrl #(
        .RST_CYCLES(RSTC),
        .STEP_W    (SW),
        .DT_W      (DW),
        .TIME_W    (TW)
    ) dut (
        .emu_clk   (emu_clk),
        .emu_rst   (emu_rst),
        .locked    (locked),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_steps (cmd_steps),
        .dt        (dt),
        .emu_ce    (emu_ce),
        .sys_rst   (sys_rst),
        .state     (state),
        .steps_left(steps_left)
`ifdef EMU_TIME_CNT_EN
        ,
        .emu_time  (emu_time)
`endif
    );

    always #5 emu_clk = ~emu_clk;

    typedef struct {
        int st;
        bit ce;
        bit srst;
        bit rdy;
        int steps;
        int tm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks        = 0;
    int errors        = 0;
    int ce_count      = 0;
    int rst_run_count = 0;

    // Global drive state used by the driver.
    bit rs_g  = 1'b1;
    bit lk_g  = 1'b0;
    int dt_g  = 0;

    // Behavioural model: mode uses the state numbering of the spec,
    // rst_left counts RESET cycles still to come, steps counts pending steps.
    int m_mode     = 0;
    int m_rst_left = 0;
    int m_steps    = 0;
    int m_time     = 0;
    bit m_ce       = 1'b0;
    bit m_srst     = 1'b1;
    bit m_l1       = 1'b0;
    bit m_ls       = 1'b0;

    function automatic void chk(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endfunction

    task automatic model_edge(input bit rs, input bit lk, input bit v,
                              input bit [1:0] op, input int n, input int d);
        bit acc;
        if (rs) begin
            m_mode = 0; m_rst_left = 0; m_steps = 0; m_time = 0;
            m_ce = 1'b0; m_srst = 1'b1; m_l1 = 1'b0; m_ls = 1'b0;
            return;
        end
        if (m_srst)    m_time = 0;
        else if (m_ce) m_time = (m_time + d) % (1 << TW);
        acc = v && m_ls && (m_mode >= 2);
        if (!m_ls) begin
            m_mode  = 0;
            m_steps = 0;
        end else if (m_mode == 0) begin
            m_mode     = 1;
            m_rst_left = RSTC;
        end else if (m_mode == 1) begin
            m_rst_left--;
            if (m_rst_left == 0) m_mode = 2;
        end else begin
            if (m_mode == 4) begin
                m_steps--;
                if (m_steps == 0) m_mode = 2;
            end
            if (acc) begin
                case (op)
                    2'd0: begin m_mode = 2; m_steps = 0; end
                    2'd1: begin m_mode = 3; m_steps = 0; end
                    2'd2: if (n != 0) begin m_mode = 4; m_steps = n; end
                    default: begin m_mode = 1; m_rst_left = RSTC; m_steps = 0; end
                endcase
            end
        end
        m_ls   = m_l1;
        m_l1   = lk;
        m_ce   = (m_mode == 3) || (m_mode == 4);
        m_srst = (m_mode <= 1);
    endtask

    task automatic cyc(input bit v, input bit [1:0] op, input int n, input int d);
        exp_t e;
        @(negedge emu_clk);
        emu_rst   = rs_g;
        locked    = lk_g;
        cmd_valid = v;
        cmd_op    = op;
        cmd_steps = SW'(n);
        dt        = DW'(d);
        model_edge(rs_g, lk_g, v, op, n, d);
        e.st    = m_mode;
        e.ce    = m_ce;
        e.srst  = m_srst;
        e.rdy   = m_ls && (m_mode >= 2);
        e.steps = m_steps;
        e.tm    = m_time;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 2'b00, 0, dt_g);
    endtask

    // Monitor: one expected entry per rising edge.
    always @(posedge emu_clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("state",      int'(state),      mon_e.st);
            chk("emu_ce",     int'(emu_ce),     int'(mon_e.ce));
            chk("sys_rst",    int'(sys_rst),    int'(mon_e.srst));
            chk("cmd_ready",  int'(cmd_ready),  int'(mon_e.rdy));
            chk("steps_left", int'(steps_left), mon_e.steps);
`ifdef EMU_TIME_CNT_EN
            chk("emu_time",   int'(emu_time),   mon_e.tm);
`endif
            if (emu_ce) ce_count++;
            if (state == 3'd1 && sys_rst) rst_run_count++;
        end
    end

    initial begin
        // Reset held, then released with no lock: stays in WAIT_LOCK.
        rs_g = 1'b1; lk_g = 1'b0;
        idle(4);
        rs_g = 1'b0;
        idle(8);

        // Lock rises: synchroniser delay, then exactly RSTC reset cycles.
        rst_run_count = 0;
        lk_g = 1'b1;
        idle(RSTC + 6);
        chk("lockup_reset_cycles", rst_run_count, RSTC);
        chk("lockup_idle_state", int'(state), 2);

        // STEP 5 from IDLE, then STEP 0.
        dt_g = 7;
        ce_count = 0;
        cyc(1'b1, 2'b10, 5, dt_g);
        idle(8);
        chk("step5_ce_count", ce_count, 5);
        chk("step5_back_idle", int'(state), 2);
        ce_count = 0;
        cyc(1'b1, 2'b10, 0, dt_g);
        idle(4);
        chk("step0_ce_count", ce_count, 0);

        // Clear time with a RESET command, then RUN for 10 cycles and STOP.
        dt_g = 3;
        cyc(1'b1, 2'b11, 0, dt_g);
        idle(RSTC + 4);
        ce_count = 0;
        cyc(1'b1, 2'b01, 0, dt_g);
        idle(9);
        cyc(1'b1, 2'b00, 0, dt_g);
        idle(2);
        chk("run10_ce_count", ce_count, 10);
`ifdef EMU_TIME_CNT_EN
        chk("run10_emu_time", int'(emu_time), 30);
`endif

        // RESET command: time cleared, sys_rst held for RSTC cycles.
        rst_run_count = 0;
        cyc(1'b1, 2'b11, 0, dt_g);
        idle(2);
`ifdef EMU_TIME_CNT_EN
        chk("reset_emu_time", int'(emu_time), 0);
`endif
        idle(RSTC + 3);
        chk("cmd_reset_cycles", rst_run_count, RSTC);

        // Time wrap: dt=200 over two enabled cycles gives 400 mod 256.
        dt_g = 200;
        cyc(1'b1, 2'b10, 2, dt_g);
        idle(4);
`ifdef EMU_TIME_CNT_EN
        chk("wrap_emu_time", int'(emu_time), 144);
`endif
        chk("wrap_idle_state", int'(state), 2);

        // Lock loss mid-RUN with a command pending after the drop.
        dt_g = 1;
        cyc(1'b1, 2'b01, 0, dt_g);
        idle(5);
        lk_g = 1'b0;
        idle(2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'b10, 3, dt_g);
        idle(2);
        chk("lockloss_state", int'(state), 0);
        chk("lockloss_ce", int'(emu_ce), 0);
        chk("lockloss_sys_rst", int'(sys_rst), 1);
        lk_g = 1'b1;
        idle(RSTC + 6);
        chk("relock_idle_state", int'(state), 2);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) lk_g = ~lk_g;
            if (!lk_g && $urandom_range(0, 29) == 0) lk_g = 1'b1;
            rs_g = ($urandom_range(0, 1499) == 0);
            dt_g = $urandom_range(0, 255);
            if ($urandom_range(0, 2) == 0)
                cyc(1'b1, 2'($urandom_range(0, 3)), $urandom_range(0, 12), dt_g);
            else
                cyc(1'b0, 2'($urandom_range(0, 3)), $urandom_range(0, 12), dt_g);
        end
        rs_g = 1'b0;
        idle(2);
        @(posedge emu_clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
